// File: rtl/mips_dmem_responder_if.sv
// MEM-stage data bus between the MIPS core (master) and the data-memory responder (slave).
interface mips_dmem_responder_if #(
    parameter int unsigned WORD_WIDTH = 32
);
    logic                  MemRead;
    logic                  MemWrite;
    logic [WORD_WIDTH-1:0] MemAddr;
    logic [WORD_WIDTH-1:0] MemWriteData;
    logic [WORD_WIDTH-1:0] MemReadData;
    logic                  mem_stall;
    logic                  mem_fault;
    logic [WORD_WIDTH-1:0] fault_addr;

    modport master (
        output MemRead, MemWrite, MemAddr, MemWriteData,
        input  MemReadData, mem_stall, mem_fault, fault_addr
    );

    modport slave (
        input  MemRead, MemWrite, MemAddr, MemWriteData,
        output MemReadData, mem_stall, mem_fault, fault_addr
    );
endinterface

// File: rtl/mips_dmem_responder.sv
// Data-memory responder with configurable wait states, stall generation and fault capture.
// Optional performance counters are enabled by defining DMEM_PERF_COUNTERS_EN.
module mips_dmem_responder #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mips_dmem_responder_if.slave    bus
`ifdef DMEM_PERF_COUNTERS_EN
    ,
    output logic [31:0]             rd_count,
    output logic [31:0]             wr_count,
    output logic [31:0]             stall_cycles
`endif
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 3;
    localparam int unsigned AW1   = WORD_WIDTH + 1;
    localparam logic [AW1-1:0] ADDR_LIMIT = AW1'(DEPTH * 4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WORD_WIDTH-1:0]   rdata_q;
    logic [WORD_WIDTH-1:0]   faddr_q;
    logic [WORD_WIDTH-1:0]   mem_q [DEPTH];

    logic [IDX_W-1:0]        addr_idx;
    logic                    misalign, oob, both, any_req;
    logic                    fault_c, go_c;
    logic                    stall_c, capture_c, wr_en_c;
    logic [IDX_W-1:0]        cap_idx_c, wr_idx_c;

    assign addr_idx = bus.MemAddr[IDX_W+1:2];
    assign misalign = |bus.MemAddr[1:0];
    assign oob      = {1'b0, bus.MemAddr} >= ADDR_LIMIT;
    assign both     = bus.MemRead & bus.MemWrite;
    assign any_req  = bus.MemRead | bus.MemWrite;

    // Faults and new accesses are only recognised while idle; reset masks both.
    assign fault_c = reset_n && (state_q == S_IDLE) && any_req && (misalign || oob || both);
    assign go_c    = reset_n && (state_q == S_IDLE) && (bus.MemRead ^ bus.MemWrite) && !misalign && !oob;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        stall_c   = 1'b0;
        capture_c = 1'b0;
        wr_en_c   = 1'b0;
        cap_idx_c = idx_q;
        wr_idx_c  = idx_q;
        case (state_q)
            S_IDLE: begin
                if (go_c) begin
                    if (LATENCY == 0) begin
                        capture_c = bus.MemRead;
                        cap_idx_c = addr_idx;
                        wr_en_c   = bus.MemWrite;
                        wr_idx_c  = addr_idx;
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = CNT_W'(LATENCY - 1);
                        idx_d   = addr_idx;
                        if (LATENCY == 1) begin
                            state_d   = S_DONE;
                            capture_c = bus.MemRead;
                            cap_idx_c = addr_idx;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d   = S_DONE;
                    capture_c = bus.MemRead;
                end
            end
            S_DONE: begin
                // A write dropped by the core before this cycle is suppressed.
                wr_en_c = reset_n && bus.MemWrite;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            faddr_q <= '0;
        end else begin
            if (capture_c) rdata_q <= mem_q[cap_idx_c];
            if (fault_c)   faddr_q <= bus.MemAddr;
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[wr_idx_c] <= bus.MemWriteData;
    end

    assign bus.mem_stall   = reset_n & stall_c;
    assign bus.mem_fault   = fault_c;
    assign bus.fault_addr  = faddr_q;
    assign bus.MemReadData = ((LATENCY == 0) && go_c && bus.MemRead) ? mem_q[addr_idx] : rdata_q;

`ifdef DMEM_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_count     <= '0;
            wr_count     <= '0;
            stall_cycles <= '0;
        end else begin
            if (capture_c)     rd_count     <= rd_count + 32'd1;
            if (wr_en_c)       wr_count     <= wr_count + 32'd1;
            if (bus.mem_stall) stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mips_dmem_responder.md
Name: mips_dmem_responder

Overview:
- Data-memory responder on the far side of the MEM-stage data interface of the pipelined MIPS core.
- Accepts read/write requests (MemRead, MemWrite, byte address, write data) and returns read data.
- Inserts a configurable number of wait states, asserting a stall to freeze the pipeline while an access is outstanding.
- Rejects misaligned and out-of-range accesses with a fault indication and captured fault address.

Parameters:
WORD_WIDTH, 32, data and address width in bits.
DEPTH, 1024, number of WORD_WIDTH words in the array; power of two.
LATENCY, 2, wait-state cycles per access; legal range 0..7.

Ports:
clk  input  1  clock, rising-edge.
reset_n  input  1  asynchronous, active-low reset.
MemRead  input  1  read request from the EX/MEM register.
MemWrite  input  1  write request from the EX/MEM register.
MemAddr  input  WORD_WIDTH  byte address (EX/MEM ALU result).
MemWriteData  input  WORD_WIDTH  store data.
MemReadData  output  WORD_WIDTH  load data.
mem_stall  output  1  high means the pipeline must hold all MEM-stage inputs stable.
mem_fault  output  1  high for the cycle in which a faulting request is presented.
fault_addr  output  WORD_WIDTH  address of the most recent faulting request.

Behaviour:
- Reset (async, reset_n low):
  - FSM to IDLE; wait counter 0.
  - MemReadData = 0, fault_addr = 0; mem_stall = 0, mem_fault = 0.
  - Array contents are not reset.
- Request: MemRead xor MemWrite high. Word index = MemAddr[log2(DEPTH)+1:2].
- Fault conditions, evaluated only in IDLE:
  - MemAddr[1:0] != 0, or MemAddr >= DEPTH*4, or MemRead and MemWrite both high.
  - Effect: mem_fault = 1 combinationally that cycle; no array access; mem_stall = 0; fault_addr loaded with MemAddr at the next edge; FSM stays IDLE.
- LATENCY = 0:
  - No FSM activity; mem_stall is constantly 0.
  - MemReadData = array[index] combinationally when MemRead is high; otherwise it holds its last registered read value.
  - Write commits at the rising edge of the request cycle.
- LATENCY = N > 0, FSM states IDLE, WAIT, DONE:
  - IDLE + valid request: mem_stall = 1 combinationally; counter loaded with N-1.
    - If N = 1, go to DONE; else go to WAIT.
  - WAIT: mem_stall = 1; counter decrements each cycle; when counter = 1, go to DONE.
  - Exactly N stall cycles total, including the IDLE request cycle.
  - The edge leaving the last stall cycle captures array[index] into the read register when MemRead is high.
  - DONE: mem_stall = 0.
    - MemReadData = captured word.
    - A write commits MemWriteData at the edge ending DONE.
    - Always DONE -> IDLE.
  - A request still present in IDLE after DONE, because the pipeline is held by another hazard, is re-executed. This is harmless: loads are idempotent and stores rewrite the same data.
  - Inputs changing during WAIT are a protocol violation; the FSM still completes using the index latched at request time.
  - Request deasserted during WAIT: the access still completes, and the write is suppressed if MemWrite is low in DONE.
- MemReadData is unchanged by writes and by idle cycles.
- Reset mid-access: FSM returns to IDLE immediately; a pending write is discarded; stall drops asynchronously.

Optional Feature:
- Macro: DMEM_PERF_COUNTERS_EN.
- When defined, the block adds three 32-bit output ports:
  - rd_count: increments at completion of each non-faulting read.
  - wr_count: increments when each write commits.
  - stall_cycles: increments on every cycle mem_stall = 1.
  - All three reset to 0 and wrap at 2^32.
- When undefined, these ports and registers are absent, and behaviour is otherwise identical.

Test Plan:
- LATENCY=2: write 0xDEADBEEF to address 0x10, then read 0x10 -> mem_stall high exactly 2 cycles per access; MemReadData = 0xDEADBEEF in the read's DONE cycle.
- LATENCY=0: write 0x12345678 to 0x0, read 0x0 next cycle -> mem_stall never high; same-cycle MemReadData = 0x12345678.
- Read at 0x6 (misaligned) -> mem_fault = 1 that cycle, no stall, fault_addr = 0x6 next cycle, array unchanged.
- Read at 0x1000 with DEPTH=1024 (out of range) -> mem_fault = 1, fault_addr = 0x1000.
- MemRead and MemWrite both high at 0x20 -> mem_fault = 1; a later read of 0x20 returns the prior contents.
- LATENCY=3: write 0xA5A5A5A5 to 0x8, assert reset_n low in the 2nd stall cycle -> mem_stall = 0 immediately; a later read of 0x8 returns the old value.
